// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
// Bundles the signals between decode, the immediate generator FIFO and execute.
//   in_valid/in_ready/instr/immsrc : producer side (decode -> generator)
//   flush                          : synchronous queue flush
//   out_valid/out_ready            : consumer handshake (generator -> execute)
//   immext/imm_fmt/illegal         : head-entry payload
//   err_count                      : saturating count of accepted illegal entries
// The slave modport is the generator's view; master is the surrounding logic.
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      immsrc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] immext;
    logic [2:0]      imm_fmt;
    logic            illegal;
    logic [15:0]     err_count;

    modport master (
        output in_valid, instr, immsrc, flush, out_ready,
        input  in_ready, out_valid, immext, imm_fmt, illegal, err_count
    );

    modport slave (
        input  in_valid, instr, immsrc, flush, out_ready,
        output in_ready, out_valid, immext, imm_fmt, illegal, err_count
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Decode-stage immediate generator followed by a DEPTH-entry FIFO so decode
// and execute can stall independently.
// Parameters:
//   XLEN        : immediate width, 32 or 64
//   DEPTH       : FIFO entries, power of two, >= 2
//   AUTO_DECODE : 1 = format from opcode/funct3, 0 = format from immsrc
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears queue and error counter
//   bus   : imm_gen_pipe_if slave (handshakes, payload, flush, err_count)
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int AUTO_DECODE = 1
) (
    input logic           clk,
    input logic           reset,
    imm_gen_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100,
        FMT_Z = 3'b101,
        FMT_N = 3'b110,
        FMT_X = 3'b111
    } fmt_e;

    // ------------------------------------------------------------------
    // Format selection
    // ------------------------------------------------------------------
    fmt_e dec_fmt;
    fmt_e fmt;

    always_comb begin
        dec_fmt = FMT_X;
        case (bus.instr[6:0])
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b0011011: dec_fmt = FMT_I;
            7'b0100011:             dec_fmt = FMT_S;
            7'b1100011:             dec_fmt = FMT_B;
            7'b1101111:             dec_fmt = FMT_J;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            // SYSTEM: funct3[2] selects the CSR immediate (uimm) forms
            7'b1110011:             dec_fmt = bus.instr[14] ? FMT_Z : FMT_I;
            7'b0110011, 7'b0111011: dec_fmt = FMT_N;
            default:                dec_fmt = FMT_X;
        endcase
    end

    assign fmt = (AUTO_DECODE != 0) ? dec_fmt : fmt_e'(bus.immsrc);

    // ------------------------------------------------------------------
    // Immediate extraction and extension
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm;
    logic            ill;

    always_comb begin
        imm = '0;
        ill = 1'b0;
        case (fmt)
            FMT_I: imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
            FMT_S: imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            FMT_B: imm = {{(XLEN-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
                          bus.instr[30:25], bus.instr[11:8], 1'b0};
            FMT_J: imm = {{(XLEN-21){bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                          bus.instr[20], bus.instr[30:21], 1'b0};
            FMT_U: imm = {{(XLEN-32){bus.instr[31]}}, bus.instr[31:12], 12'b0};
            FMT_Z: imm = {{(XLEN-5){1'b0}}, bus.instr[19:15]};
            FMT_N: imm = '0;
            default: begin
                imm = '0;
                ill = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   err_q;
    logic          push;
    logic          pop;

    // Ready/valid come only from the registered count, never from inputs.
    assign bus.in_ready  = (count != CNT_FULL);
    assign bus.out_valid = (count != '0);

    // Flush discards any same-cycle transfer on either side.
    assign push = bus.in_valid  && bus.in_ready  && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flush leaves the counter alone; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (push && ill && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign bus.err_count = err_q;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mem_imm [DEPTH];
    logic [2:0]      mem_fmt [DEPTH];
    logic            mem_ill [DEPTH];

    // NOTE: the entry array has no reset; count gates every read, so stale
    // contents are never observable and the storage stays plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wr_ptr] <= imm;
            mem_fmt[wr_ptr] <= fmt;
            mem_ill[wr_ptr] <= ill;
        end
    end

    // Payload reads as zero whenever the queue is empty.
    assign bus.immext  = bus.out_valid ? mem_imm[rd_ptr] : '0;
    assign bus.imm_fmt = bus.out_valid ? mem_fmt[rd_ptr] : 3'b000;
    assign bus.illegal = bus.out_valid ? mem_ill[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe. Three instances share clk/reset:
//   a : XLEN=32, DEPTH=2, AUTO_DECODE=1
//   b : XLEN=64, DEPTH=2, AUTO_DECODE=1
//   c : XLEN=32, DEPTH=4, AUTO_DECODE=0
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    imm_gen_pipe_if #(.XLEN(32)) a_if ();
    imm_gen_pipe_if #(.XLEN(64)) b_if ();
    imm_gen_pipe_if #(.XLEN(32)) c_if ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1)) u_a (
        .clk(clk), .reset(reset), .bus(a_if.slave));
    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .AUTO_DECODE(1)) u_b (
        .clk(clk), .reset(reset), .bus(b_if.slave));
    imm_gen_pipe #(.XLEN(32), .DEPTH(4), .AUTO_DECODE(0)) u_c (
        .clk(clk), .reset(reset), .bus(c_if.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Single-cycle push into instance 0/1/2; starts and ends just after a negedge.
    task automatic push(input int which, input logic [31:0] w, input logic [2:0] src);
        case (which)
            0: begin a_if.in_valid = 1'b1; a_if.instr = w; end
            1: begin b_if.in_valid = 1'b1; b_if.instr = w; end
            default: begin c_if.in_valid = 1'b1; c_if.instr = w; c_if.immsrc = src; end
        endcase
        @(negedge clk);
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        c_if.in_valid = 1'b0;
    endtask

    task automatic pop(input int which);
        case (which)
            0:       a_if.out_ready = 1'b1;
            1:       b_if.out_ready = 1'b1;
            default: c_if.out_ready = 1'b1;
        endcase
        @(negedge clk);
        a_if.out_ready = 1'b0;
        b_if.out_ready = 1'b0;
        c_if.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] w;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    vec_t avec [7];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a_if.in_valid = 1'b0; a_if.instr = '0; a_if.immsrc = '0; a_if.flush = 1'b0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.instr = '0; b_if.immsrc = '0; b_if.flush = 1'b0; b_if.out_ready = 1'b0;
        c_if.in_valid = 1'b0; c_if.instr = '0; c_if.immsrc = '0; c_if.flush = 1'b0; c_if.out_ready = 1'b0;

        avec[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'b000};  // addi x1,x0,-1
        avec[1] = '{32'hFE112E23, 32'hFFFFFFFC, 3'b001};  // sw x1,-4(x2)
        avec[2] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'b010};  // beq x0,x0,-4
        avec[3] = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'b011};  // jal x0,-4
        avec[4] = '{32'h123452B7, 32'h12345000, 3'b100};  // lui x5,0x12345
        avec[5] = '{32'h34029073, 32'h00000340, 3'b000};  // csrrw: I form
        avec[6] = '{32'h00000033, 32'h00000000, 3'b110};  // add: no immediate

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst out_valid", 64'(a_if.out_valid), 64'd0);
        check("rst in_ready",  64'(a_if.in_ready),  64'd1);
        check("rst immext",    64'(a_if.immext),    64'd0);
        check("rst imm_fmt",   64'(a_if.imm_fmt),   64'd0);
        check("rst illegal",   64'(a_if.illegal),   64'd0);
        check("rst err_count", 64'(a_if.err_count), 64'd0);

        // One format at a time through the 32-bit auto-decode instance
        for (int i = 0; i < 7; i++) begin
            push(0, avec[i].w, 3'b000);
            check($sformatf("vec%0d valid", i),   64'(a_if.out_valid), 64'd1);
            check($sformatf("vec%0d immext", i),  64'(a_if.immext),    64'(avec[i].imm));
            check($sformatf("vec%0d fmt", i),     64'(a_if.imm_fmt),   64'(avec[i].fmt));
            check($sformatf("vec%0d illegal", i), 64'(a_if.illegal),   64'd0);
            pop(0);
            check($sformatf("vec%0d empty", i),   64'(a_if.out_valid), 64'd0);
            check($sformatf("vec%0d imm0", i),    64'(a_if.immext),    64'd0);
        end

        // Backpressure on DEPTH=2
        push(0, avec[0].w, 3'b000);
        check("bp ready after 1", 64'(a_if.in_ready), 64'd1);
        push(0, avec[1].w, 3'b000);
        check("bp ready after 2", 64'(a_if.in_ready), 64'd0);
        a_if.in_valid = 1'b1;
        a_if.instr    = avec[4].w;
        @(negedge clk);
        check("bp held ready", 64'(a_if.in_ready), 64'd0);
        check("bp held head",  64'(a_if.immext),   64'(avec[0].imm));
        a_if.out_ready = 1'b1;
        @(negedge clk);
        check("bp pop1 head",  64'(a_if.immext),   64'(avec[1].imm));
        check("bp pop1 fmt",   64'(a_if.imm_fmt),  64'd1);
        check("bp pop1 ready", 64'(a_if.in_ready), 64'd1);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        check("bp 3rd head",   64'(a_if.immext),    64'(avec[4].imm));
        check("bp 3rd fmt",    64'(a_if.imm_fmt),   64'd4);
        check("bp 3rd valid",  64'(a_if.out_valid), 64'd1);
        @(negedge clk);
        a_if.out_ready = 1'b0;
        check("bp drained",    64'(a_if.out_valid), 64'd0);

        // Illegal opcode
        push(0, 32'h00000000, 3'b000);
        check("ill valid",   64'(a_if.out_valid), 64'd1);
        check("ill illegal", 64'(a_if.illegal),   64'd1);
        check("ill fmt",     64'(a_if.imm_fmt),   64'd7);
        check("ill immext",  64'(a_if.immext),    64'd0);
        check("ill errcnt",  64'(a_if.err_count), 64'd1);
        pop(0);

        // Illegal push discarded by same-cycle flush
        a_if.flush = 1'b1;
        push(0, 32'h00000000, 3'b000);
        a_if.flush = 1'b0;
        check("flushpush valid",  64'(a_if.out_valid), 64'd0);
        check("flushpush errcnt", 64'(a_if.err_count), 64'd1);

        // Flush with two entries queued
        push(0, avec[0].w, 3'b000);
        push(0, avec[4].w, 3'b000);
        check("flush pre ready", 64'(a_if.in_ready), 64'd0);
        a_if.flush = 1'b1;
        @(negedge clk);
        a_if.flush = 1'b0;
        check("flush valid",   64'(a_if.out_valid), 64'd0);
        check("flush ready",   64'(a_if.in_ready),  64'd1);
        check("flush immext",  64'(a_if.immext),    64'd0);
        check("flush fmt",     64'(a_if.imm_fmt),   64'd0);
        check("flush errcnt",  64'(a_if.err_count), 64'd1);

        // XLEN=64 instance
        push(1, 32'hFFF00093, 3'b000);
        check("x64 addi imm", 64'(b_if.immext),  64'hFFFFFFFFFFFFFFFF);
        check("x64 addi fmt", 64'(b_if.imm_fmt), 64'd0);
        pop(1);
        push(1, 32'h3402D073, 3'b000);
        check("x64 csrrwi imm", 64'(b_if.immext),  64'd5);
        check("x64 csrrwi fmt", 64'(b_if.imm_fmt), 64'd5);
        pop(1);
        push(1, 32'h800000B7, 3'b000);
        check("x64 lui neg", 64'(b_if.immext), 64'hFFFFFFFF80000000);
        pop(1);
        push(1, 32'h123452B7, 3'b000);
        check("x64 lui pos", 64'(b_if.immext), 64'h0000000012345000);
        pop(1);

        // Explicit-format instance, DEPTH=4: fill then drain in order
        push(2, 32'hFE112E23, 3'b001);
        push(2, 32'hFE112E23, 3'b000);
        push(2, 32'h123452B7, 3'b100);
        check("c ready at 3", 64'(c_if.in_ready), 64'd1);
        push(2, 32'hFFF00093, 3'b111);
        check("c ready at 4", 64'(c_if.in_ready),  64'd0);
        check("c errcnt",     64'(c_if.err_count), 64'd1);
        check("c head0 imm",  64'(c_if.immext),    64'hFFFFFFFC);
        check("c head0 fmt",  64'(c_if.imm_fmt),   64'd1);
        pop(2);
        check("c head1 imm",  64'(c_if.immext),    64'hFFFFFFE1);
        check("c head1 fmt",  64'(c_if.imm_fmt),   64'd0);
        pop(2);
        check("c head2 imm",  64'(c_if.immext),    64'h12345000);
        pop(2);
        check("c head3 ill",  64'(c_if.illegal),   64'd1);
        check("c head3 imm",  64'(c_if.immext),    64'd0);
        check("c head3 fmt",  64'(c_if.imm_fmt),   64'd7);
        pop(2);
        check("c empty",      64'(c_if.out_valid), 64'd0);

        // Asynchronous reset with one entry queued
        push(0, avec[0].w, 3'b000);
        check("arst pre valid", 64'(a_if.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst valid",  64'(a_if.out_valid), 64'd0);
        check("arst ready",  64'(a_if.in_ready),  64'd1);
        check("arst errcnt", 64'(a_if.err_count), 64'd0);
        check("arst c err",  64'(c_if.err_count), 64'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        push(0, avec[4].w, 3'b000);
        check("post rst imm",   64'(a_if.immext),   64'(avec[4].imm));
        check("post rst ready", 64'(a_if.in_ready), 64'd1);
        pop(0);
        check("post rst empty", 64'(a_if.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
